// File: rtl/stride_predictor.sv
// N-lane last-value + stride value predictor with in-cycle feedback merging.
// Table is cleared by an FSM sweep after reset or flush; predictions are registered (1-cycle latency).
module stride_predictor #(
  parameter int P_STORAGE_SIZE = 2048,
  parameter int P_CONF_WIDTH   = 3,
  parameter int P_CONF_THRESH  = 6,
  parameter int P_NUM_PRED     = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  output logic                         init_done_o,
  input  logic [P_NUM_PRED-1:0][31:0]  fw_pc_i,
  input  logic [P_NUM_PRED-1:0]        fw_valid_i,
  output logic [P_NUM_PRED-1:0][31:0]  pred_pc_o,
  output logic [P_NUM_PRED-1:0][31:0]  pred_result_o,
  output logic [P_NUM_PRED-1:0]        pred_conf_o,
  output logic [P_NUM_PRED-1:0]        pred_valid_o,
  input  logic [P_NUM_PRED-1:0][31:0]  fb_pc_i,
  input  logic [P_NUM_PRED-1:0][31:0]  fb_actual_i,
  input  logic [P_NUM_PRED-1:0]        fb_valid_i,
  output logic [P_NUM_PRED-1:0]        fb_conflict_o
);

  localparam int P_INDEX_WIDTH = $clog2(P_STORAGE_SIZE);
  localparam logic [P_CONF_WIDTH-1:0] CONF_MAX    = '1;
  localparam logic [P_CONF_WIDTH-1:0] CONF_THRESH = P_CONF_THRESH[P_CONF_WIDTH-1:0];

  typedef struct packed {
    logic [31:0]             last;
    logic [31:0]             stride;
    logic [P_CONF_WIDTH-1:0] conf;
  } entry_t;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                                 state;
  logic   [P_INDEX_WIDTH-1:0]             sweep_cnt;
  entry_t                                 mem [P_STORAGE_SIZE];
  logic   [P_NUM_PRED-1:0][P_INDEX_WIDTH-1:0] fw_idx;
  logic   [P_NUM_PRED-1:0][P_INDEX_WIDTH-1:0] fb_idx;
  entry_t                                 fw_entry [P_NUM_PRED];
  entry_t                                 post     [P_NUM_PRED];
  logic   [P_NUM_PRED-1:0]                conflict;
  logic   [P_NUM_PRED-1:0]                wr_en;
  logic                                   run;

  assign run         = (state == ST_RUN);
  assign init_done_o = run;

  always_comb begin
    for (int k = 0; k < P_NUM_PRED; k++) begin
      fw_idx[k]   = fw_pc_i[k][P_INDEX_WIDTH-1:0];
      fb_idx[k]   = fb_pc_i[k][P_INDEX_WIDTH-1:0];
      fw_entry[k] = mem[fw_idx[k]];
    end
  end

  // Lanes are folded in ascending order so a later lane sees the post-update
  // state of the most recent earlier lane on the same index.
  always_comb begin : merge
    entry_t      post_l [P_NUM_PRED];
    entry_t      base;
    logic [31:0] ns;
    // NOTE: blocking assignments here model the sequential lane chaining within one cycle.
    base     = '0;
    ns       = '0;
    conflict = '0;
    wr_en    = '0;
    for (int k = 0; k < P_NUM_PRED; k++) begin
      base = mem[fb_idx[k]];
      for (int j = 0; j < k; j++) begin
        if (fb_valid_i[j] && fb_valid_i[k] && fb_idx[j] == fb_idx[k]) begin
          base        = post_l[j];
          conflict[k] = 1'b1;
        end
      end
      ns             = fb_actual_i[k] - base.last;
      post_l[k].last = fb_actual_i[k];
      if (ns == base.stride) begin
        post_l[k].stride = base.stride;
        post_l[k].conf   = (base.conf == CONF_MAX) ? base.conf : base.conf + 1'b1;
      end else begin
        post_l[k].stride = ns;
        post_l[k].conf   = '0;
      end
      // Only the last valid lane per index writes the final merged state.
      wr_en[k] = fb_valid_i[k] && run;
      for (int j = k + 1; j < P_NUM_PRED; j++) begin
        if (fb_valid_i[j] && fb_idx[j] == fb_idx[k]) wr_en[k] = 1'b0;
      end
    end
    for (int k = 0; k < P_NUM_PRED; k++) post[k] = post_l[k];
  end

  // NOTE: the table has no reset; it is cleared by the INIT sweep instead.
  always_ff @(posedge clk_i) begin
    if (state == ST_INIT) begin
      mem[sweep_cnt] <= '0;
    end else begin
      for (int k = 0; k < P_NUM_PRED; k++) begin
        if (wr_en[k]) mem[fb_idx[k]] <= post[k];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= ST_INIT;
      sweep_cnt     <= '0;
      pred_pc_o     <= '0;
      pred_result_o <= '0;
      pred_conf_o   <= '0;
      pred_valid_o  <= '0;
      fb_conflict_o <= '0;
    end else begin
      pred_pc_o <= fw_pc_i;
      for (int k = 0; k < P_NUM_PRED; k++) begin
        pred_valid_o[k]  <= fw_valid_i[k] && run;
        pred_result_o[k] <= (fw_valid_i[k] && run) ? fw_entry[k].last + fw_entry[k].stride : '0;
        pred_conf_o[k]   <= fw_valid_i[k] && run && (fw_entry[k].conf >= CONF_THRESH);
      end
      fb_conflict_o <= run ? conflict : '0;

      case (state)
        ST_INIT: begin
          if (flush_i) begin
            sweep_cnt <= '0;
          end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
            if (sweep_cnt == '1) state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (flush_i) begin
            state     <= ST_INIT;
            sweep_cnt <= '0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_stride_predictor.sv
// Scoreboard bench for stride_predictor: expected predictions are queued when a lookup is
// driven and compared when pred_valid_o appears; scenario tasks check FSM and conflict behaviour.
module tb_stride_predictor;

  localparam int N       = 4;
  localparam int SIZE    = 2048;
  localparam int TIMEOUT = 3000;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              flush_i = 1'b0;
  logic              init_done_o;
  logic [N-1:0][31:0] fw_pc_i = '0;
  logic [N-1:0]       fw_valid_i = '0;
  logic [N-1:0][31:0] pred_pc_o;
  logic [N-1:0][31:0] pred_result_o;
  logic [N-1:0]       pred_conf_o;
  logic [N-1:0]       pred_valid_o;
  logic [N-1:0][31:0] fb_pc_i = '0;
  logic [N-1:0][31:0] fb_actual_i = '0;
  logic [N-1:0]       fb_valid_i = '0;
  logic [N-1:0]       fb_conflict_o;

  stride_predictor #(
    .P_STORAGE_SIZE(SIZE), .P_CONF_WIDTH(3), .P_CONF_THRESH(6), .P_NUM_PRED(N)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .init_done_o(init_done_o),
    .fw_pc_i(fw_pc_i), .fw_valid_i(fw_valid_i),
    .pred_pc_o(pred_pc_o), .pred_result_o(pred_result_o),
    .pred_conf_o(pred_conf_o), .pred_valid_o(pred_valid_o),
    .fb_pc_i(fb_pc_i), .fb_actual_i(fb_actual_i), .fb_valid_i(fb_valid_i),
    .fb_conflict_o(fb_conflict_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] result;
    logic        conf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  // Monitor: valid lanes are popped in lane order; invalid lanes must hold result/conf at 0.
  always @(negedge clk_i) begin
    for (int k = 0; k < N; k++) begin
      if (pred_valid_o[k]) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL pred_unexpected lane=%0d got pc=%h result=%h, required no prediction",
                   k, pred_pc_o[k], pred_result_o[k]);
        end else begin
          mon_e = sb.pop_front();
          if ({pred_pc_o[k], pred_result_o[k], pred_conf_o[k]} !== {mon_e.pc, mon_e.result, mon_e.conf}) begin
            n_err++;
            $display("FAIL pred lane=%0d got pc=%h result=%h conf=%b, required pc=%h result=%h conf=%b",
                     k, pred_pc_o[k], pred_result_o[k], pred_conf_o[k], mon_e.pc, mon_e.result, mon_e.conf);
          end
        end
      end else if (rst_ni) begin
        n_cmp++;
        if (pred_result_o[k] !== 32'h0 || pred_conf_o[k] !== 1'b0) begin
          n_err++;
          $display("FAIL invalid_lane lane=%0d got result=%h conf=%b, required 0/0",
                   k, pred_result_o[k], pred_conf_o[k]);
        end
      end
    end
  end

  task automatic set_fw(input int lane, input logic [31:0] pc, input logic [31:0] res, input logic conf);
    exp_t e;
    fw_pc_i[lane]    = pc;
    fw_valid_i[lane] = 1'b1;
    e.pc = pc; e.result = res; e.conf = conf;
    sb.push_back(e);
  endtask

  task automatic set_fb(input int lane, input logic [31:0] pc, input logic [31:0] actual);
    fb_pc_i[lane]     = pc;
    fb_actual_i[lane] = actual;
    fb_valid_i[lane]  = 1'b1;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    fw_valid_i = '0;
    fb_valid_i = '0;
    flush_i    = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] actual);
    set_fb(0, pc, actual);
    step();
  endtask

  task automatic wait_run(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk_i);
      #1;
      cycles++;
    end while (!init_done_o && cycles < TIMEOUT);
  endtask

  task automatic test_reset();
    int cycles;
    fw_pc_i    = {32'h30, 32'h20, 32'h10, 32'h40};
    fw_valid_i = '1;
    fb_pc_i    = {N{32'h40}};
    fb_actual_i = {32'h4, 32'h3, 32'h2, 32'h1};
    fb_valid_i = '1;
    repeat (3) @(posedge clk_i);
    #1;
    n_cmp++;
    if ({init_done_o, pred_valid_o, fb_conflict_o, pred_pc_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got done=%b valid=%b conflict=%b pc0=%h, required all 0",
               init_done_o, pred_valid_o, fb_conflict_o, pred_pc_o[0]);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    cycles = 0;
    do begin
      @(posedge clk_i);
      #1;
      cycles++;
      if (cycles == 100) begin
        n_cmp++;
        if (pred_valid_o !== '0 || fb_conflict_o !== '0 || init_done_o !== 1'b0) begin
          n_err++;
          $display("FAIL init_ignores_traffic got valid=%b conflict=%b done=%b, required 0/0/0",
                   pred_valid_o, fb_conflict_o, init_done_o);
        end
      end
    end while (!init_done_o && cycles < TIMEOUT);
    fw_valid_i = '0;
    fb_valid_i = '0;
    n_cmp++;
    if (cycles != SIZE) begin
      n_err++;
      $display("FAIL init_length got %0d cycles, required %0d", cycles, SIZE);
    end
  endtask

  task automatic test_training();
    train(32'h40, 32'd10);
    train(32'h40, 32'd20);
    train(32'h40, 32'd30);
    set_fw(0, 32'h40, 32'd40, 1'b0);
    set_fw(1, 32'h44, 32'd0, 1'b0);
    step();
    train(32'h40, 32'd40);
    train(32'h40, 32'd50);
    train(32'h40, 32'd60);
    set_fw(2, 32'h40, 32'd70, 1'b0);   // conf 5, just below threshold
    step();
    train(32'h40, 32'd70);
    set_fw(0, 32'h40, 32'd80, 1'b1);   // conf 6, at threshold
    step();
    train(32'h40, 32'd80);
    train(32'h40, 32'd90);
    set_fw(3, 32'h40, 32'd100, 1'b1);  // saturated
    step();
  endtask

  task automatic test_merge();
    set_fb(0, 32'h80, 32'd5);
    set_fb(1, 32'h80, 32'd7);
    set_fb(2, 32'h80, 32'd9);
    step();
    n_cmp++;
    if (fb_conflict_o !== 4'b0110) begin
      n_err++;
      $display("FAIL merge_conflict got %b, required 0110", fb_conflict_o);
    end
    set_fw(1, 32'h80, 32'd11, 1'b0);
    step();
    n_cmp++;
    if (fb_conflict_o !== 4'b0000) begin
      n_err++;
      $display("FAIL conflict_clear got %b, required 0000", fb_conflict_o);
    end
    // 0x900 aliases 0x100 in an 11-bit index.
    set_fb(0, 32'h100, 32'd100);
    set_fb(1, 32'h104, 32'd50);
    set_fb(2, 32'h900, 32'd130);
    step();
    n_cmp++;
    if (fb_conflict_o !== 4'b0100) begin
      n_err++;
      $display("FAIL alias_conflict got %b, required 0100", fb_conflict_o);
    end
    set_fw(0, 32'h100, 32'd160, 1'b0);
    set_fw(1, 32'h104, 32'd100, 1'b0);
    set_fw(3, 32'h900, 32'd160, 1'b0);
    step();
  endtask

  task automatic test_read_before_write();
    set_fw(0, 32'h80, 32'd11, 1'b0);
    set_fb(0, 32'h80, 32'd11);
    step();
    set_fw(0, 32'h80, 32'd13, 1'b0);
    step();
  endtask

  task automatic test_wrap();
    train(32'h200, 32'hFFFF_FFE0);
    train(32'h200, 32'hFFFF_FFF0);
    set_fw(0, 32'h200, 32'h0, 1'b0);
    step();
    train(32'h200, 32'h0);
    set_fw(0, 32'h200, 32'h10, 1'b0);
    step();
  endtask

  task automatic test_flush();
    int cycles;
    set_fw(0, 32'h40, 32'd100, 1'b1);
    set_fb(1, 32'h300, 32'd77);
    flush_i = 1'b1;
    step();
    n_cmp++;
    if (init_done_o !== 1'b0) begin
      n_err++;
      $display("FAIL flush_enters_init got done=%b, required 0", init_done_o);
    end
    wait_run(cycles);
    n_cmp++;
    if (cycles != SIZE) begin
      n_err++;
      $display("FAIL flush_sweep_length got %0d cycles, required %0d", cycles, SIZE);
    end
    set_fw(0, 32'h40, 32'd0, 1'b0);
    set_fw(1, 32'h300, 32'd0, 1'b0);
    step();
    step();
  endtask

  task automatic test_restart();
    int cycles;
    flush_i = 1'b1;
    step();
    repeat (500) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    step();
    wait_run(cycles);
    n_cmp++;
    if (cycles != SIZE) begin
      n_err++;
      $display("FAIL flush_in_init_length got %0d cycles, required %0d", cycles, SIZE);
    end
    train(32'h80, 32'd21);
    flush_i = 1'b1;
    fw_pc_i[2] = 32'hDEAD_BEEF;
    step();
    repeat (100) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if (init_done_o !== 1'b0 || pred_pc_o[2] !== 32'h0) begin
      n_err++;
      $display("FAIL async_reset got done=%b pc2=%h, required 0/00000000", init_done_o, pred_pc_o[2]);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    wait_run(cycles);
    n_cmp++;
    if (cycles != SIZE) begin
      n_err++;
      $display("FAIL reset_mid_init_length got %0d cycles, required %0d", cycles, SIZE);
    end
    set_fw(0, 32'h80, 32'd0, 1'b0);
    step();
    step();
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_training();
    test_merge();
    test_read_before_write();
    test_wrap();
    test_flush();
    test_restart();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
